uart_rx_core: RTL

Serial receive engine for the UART peripheral path: recovers 8N1 frames from the Bluetooth module's TX line into a one-byte holding register. It presents the `rx_data` / `rx_avail` / `rx_error` / `rx_ack` handshake that the memory-mapped UART wrapper consumes. Timing uses a 16x oversampled bit clock derived from the system clock, with mid-bit majority voting.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_core_if.sv | 30 +++
 rtl/uart_tick_gen.sv | 35 +++
 rtl/uart_rx_core.sv | 139 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX engines: FSM encoding, oversample ratio, divider math.
// Declarations only; no timing and no flow control.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // Holding-register contents committed at the stop-bit vote
  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } uart_frame_t;

  function automatic int uart_div(input int freq_hz, input int baud);
    return freq_hz / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Serial line plus byte-holding handshake between the RX engine and the register wrapper.
// master = receive engine, slave = consumer that owns the line input and the ack pulse.
interface uart_rx_core_if;

  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_error;
  logic       rx_overrun;
  logic       rx_ack;

  modport master (
    input  uart_rxd,
    input  rx_ack,
    output rx_data,
    output rx_avail,
    output rx_error,
    output rx_overrun
  );

  modport slave (
    output uart_rxd,
    output rx_ack,
    input  rx_data,
    input  rx_avail,
    input  rx_error,
    input  rx_overrun
  );

endinterface

// File: rtl/uart_tick_gen.sv
// Free-running 16x oversample strobe: one-clk tick every freq_hz/(16*baud) clocks.
// Latency: tick is a decode of the divider counter; no backpressure, it never stops.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int freq_hz = 100000000,
  parameter int baud    = 115200
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = uart_div(freq_hz, baud);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_div_too_small
    $error("uart_tick_gen: freq_hz/(16*baud) must be at least 2");
  end

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == CW'(DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = (div_cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 receive engine: 2-flop sync, 16x oversampling, 3-sample majority vote, one-byte holding register.
// Latency ~2 clk + 9.5 bits + 1 clk from start edge; no backpressure, an unacked byte is overwritten and rx_overrun set.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int freq_hz = 100000000,
  parameter int baud    = 115200
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_core_if.master bus
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_DATA  = DATA;
  localparam logic [2:0] S_STOP  = STOP;
  localparam logic [2:0] S_BREAK = BREAK;

  logic        rx_meta;
  logic        rxs;
  logic        tick;
  logic [2:0]  state;
  logic [3:0]  os_cnt;
  logic [3:0]  os_nxt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        smp7;
  logic        smp8;
  logic        vote;
  logic        vote_pt;
  logic        wrap;
  logic        commit;
  uart_frame_t held;
  logic        avail_q;
  logic        ovr_q;

  uart_tick_gen #(
    .freq_hz (freq_hz),
    .baud    (baud)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= bus.uart_rxd;
      rxs     <= rx_meta;
    end
  end

  // Samples are tagged with the os_cnt value the tick advances to; the vote lands on the step to 9.
  assign os_nxt  = os_cnt + 4'd1;
  assign vote_pt = tick && (os_nxt == 4'd9);
  assign wrap    = tick && (os_cnt == 4'd15);
  assign vote    = (smp7 & smp8) | (smp7 & rxs) | (smp8 & rxs);
  assign commit  = (state == S_STOP) && vote_pt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt <= '0;
      smp7   <= 1'b0;
      smp8   <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= os_nxt;
      end
      if (tick && os_nxt == 4'd7) smp7 <= rxs;
      if (tick && os_nxt == 4'd8) smp8 <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rxs) state <= S_START;
        end
        S_START: begin
          if (vote_pt && vote) begin
            state <= S_IDLE;
          end else if (wrap) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (vote_pt) shreg <= {vote, shreg[7:1]};
          if (wrap) begin
            if (bit_idx == 3'd7) state <= S_STOP;
            bit_idx <= bit_idx + 3'd1;
          end
        end
        S_STOP: begin
          if (vote_pt) state <= vote ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          // Line held low past the stop bit: wait it out rather than decode zeros
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held    <= '0;
      avail_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (commit) begin
      held.data <= shreg;
      held.err  <= ~vote;
      avail_q   <= 1'b1;
      ovr_q     <= avail_q & ~bus.rx_ack;
    end else if (bus.rx_ack) begin
      held.err <= 1'b0;
      avail_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end
  end

  assign bus.rx_data    = held.data;
  assign bus.rx_error   = held.err;
  assign bus.rx_avail   = avail_q;
  assign bus.rx_overrun = ovr_q;

endmodule
